// File: rtl/chan_override_pkg.sv
// Shared types for the per-channel override capture block.
// Each channel is NORMAL, FORCED or HOLD.
package chan_override_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        NORMAL = 2'd0,
        FORCED = 2'd1,
        HOLD   = 2'd2
    } ovr_state_t;

    // Any state other than NORMAL presents the override value.
    function automatic logic is_overridden(input ovr_state_t st);
        return st != NORMAL;
    endfunction

endpackage

// File: rtl/chan_override_slice.sv
// One capture channel: shadow register, override register, post-release hold counter
// and the registered output mux, all driven from a single state machine.
module chan_override_slice
    import chan_override_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned HOLD_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic              force_en,
    input  logic [WIDTH-1:0]  force_val,
    input  logic              release_req,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic [WIDTH-1:0]  out,
    output logic [WIDTH-1:0]  shadow,
    output logic              forced
);

    ovr_state_t        state_q;
    logic [WIDTH-1:0]  ovr_q;
    logic [HOLD_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORMAL;
            ovr_q   <= '0;
            cnt_q   <= '0;
            out     <= '0;
            shadow  <= '0;
            forced  <= 1'b0;
        end else begin
            // The shadow tracks the input regardless of override state.
            shadow <= in;
            unique case (state_q)
                NORMAL: begin
                    if (force_en) begin
                        state_q <= FORCED;
                        ovr_q   <= force_val;
                        out     <= force_val;
                        forced  <= 1'b1;
                    end else begin
                        out    <= in;
                        forced <= 1'b0;
                    end
                end
                FORCED: begin
                    if (force_en) begin
                        ovr_q  <= force_val;
                        out    <= force_val;
                        forced <= 1'b1;
                    end else if (release_req) begin
                        if (hold_cycles == '0) begin
                            state_q <= NORMAL;
                            out     <= in;
                            forced  <= 1'b0;
                        end else begin
                            // Count reaches zero on the last held cycle, giving N held cycles.
                            state_q <= HOLD;
                            cnt_q   <= hold_cycles - HOLD_W'(1);
                            out     <= ovr_q;
                            forced  <= 1'b1;
                        end
                    end else begin
                        out    <= ovr_q;
                        forced <= 1'b1;
                    end
                end
                HOLD: begin
                    if (force_en) begin
                        state_q <= FORCED;
                        ovr_q   <= force_val;
                        out     <= force_val;
                        forced  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= NORMAL;
                        out     <= in;
                        forced  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - HOLD_W'(1);
                        out    <= ovr_q;
                        forced <= 1'b1;
                    end
                end
                default: begin
                    state_q <= NORMAL;
                    out     <= in;
                    forced  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/chan_override_capture.sv
// Multi-channel capture register with independent per-channel override and release hold.
// busy reports whether any channel is currently presenting an override.
module chan_override_capture
    import chan_override_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned NCHAN  = 2,
    parameter int unsigned HOLD_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCHAN*WIDTH-1:0] in,
    input  logic [NCHAN-1:0]       force_en,
    input  logic [NCHAN*WIDTH-1:0] force_val,
    input  logic [NCHAN-1:0]       release_req,
    input  logic [HOLD_W-1:0]      hold_cycles,
    output logic [NCHAN*WIDTH-1:0] out,
    output logic [NCHAN*WIDTH-1:0] shadow,
    output logic [NCHAN-1:0]       forced,
    output logic                   busy
);

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        chan_override_slice #(
            .WIDTH  (WIDTH),
            .HOLD_W (HOLD_W)
        ) u_slice (
            .clk         (clk),
            .rst         (rst),
            .in          (in[c*WIDTH +: WIDTH]),
            .force_en    (force_en[c]),
            .force_val   (force_val[c*WIDTH +: WIDTH]),
            .release_req (release_req[c]),
            .hold_cycles (hold_cycles),
            .out         (out[c*WIDTH +: WIDTH]),
            .shadow      (shadow[c*WIDTH +: WIDTH]),
            .forced      (forced[c])
        );
    end

    always_comb begin
        busy = |forced;
    end

endmodule

// File: tb/tb_chan_override_capture.sv
// Directed, table-driven bench for chan_override_capture at four channels of four bits.
// Each table row is one clock: inputs driven on the falling edge, outputs checked after the rising edge.
module tb_chan_override_capture;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned NCHAN  = 4;
    localparam int unsigned HOLD_W = 3;

    typedef struct {
        logic        r;
        logic [15:0] i;
        logic [3:0]  fe;
        logic [15:0] fv;
        logic [3:0]  rr;
        logic [2:0]  hc;
        logic [15:0] eo;
        logic [15:0] es;
        logic [3:0]  ef;
        logic        eb;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  fen;
    logic [15:0] fval;
    logic [3:0]  rreq;
    logic [2:0]  hcyc;
    logic [15:0] dout;
    logic [15:0] dshadow;
    logic [3:0]  dforced;
    logic        dbusy;

    int checks = 0;
    int passes = 0;
    vec_t vecs[$];

    chan_override_capture #(
        .WIDTH  (WIDTH),
        .NCHAN  (NCHAN),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (din),
        .force_en    (fen),
        .force_val   (fval),
        .release_req (rreq),
        .hold_cycles (hcyc),
        .out         (dout),
        .shadow      (dshadow),
        .forced      (dforced),
        .busy        (dbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input logic r, input logic [15:0] i, input logic [3:0] fe,
                       input logic [15:0] fv, input logic [3:0] rr, input logic [2:0] hc,
                       input logic [15:0] eo, input logic [15:0] es, input logic [3:0] ef,
                       input logic eb);
        vec_t v;
        v.r = r; v.i = i; v.fe = fe; v.fv = fv; v.rr = rr; v.hc = hc;
        v.eo = eo; v.es = es; v.ef = ef; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [15:0] i, input logic [3:0] fe,
                         input logic [15:0] fv, input logic [3:0] rr, input logic [2:0] hc);
        @(negedge clk);
        rst = r; din = i; fen = fe; fval = fv; rreq = rr; hcyc = hc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; din = '0; fen = '0; fval = '0; rreq = '0; hcyc = '0;

        //   rst in       fe    fv       rr    hc  out      shadow   forced busy
        // reset and plain capture, reset asserted mid-run
        add(1, 16'h0000, 4'h0, 16'h0000, 4'h0, 0, 16'h0000, 16'h0000, 4'h0, 0);
        add(0, 16'h1234, 4'h0, 16'h0000, 4'h0, 0, 16'h1234, 16'h1234, 4'h0, 0);
        add(1, 16'h5678, 4'h0, 16'h0000, 4'h0, 0, 16'h0000, 16'h0000, 4'h0, 0);
        add(0, 16'h0005, 4'h0, 16'h0000, 4'h0, 0, 16'h0005, 16'h0005, 4'h0, 0);
        // ch0 forced to A, input toggling 3/C, release with hold 3
        add(0, 16'h0003, 4'h1, 16'h000A, 4'h0, 0, 16'h000A, 16'h0003, 4'h1, 1);
        add(0, 16'h000C, 4'h0, 16'h0000, 4'h0, 0, 16'h000A, 16'h000C, 4'h1, 1);
        add(0, 16'h0003, 4'h0, 16'h0000, 4'h1, 3, 16'h000A, 16'h0003, 4'h1, 1);
        add(0, 16'h000C, 4'h0, 16'h0000, 4'h0, 0, 16'h000A, 16'h000C, 4'h1, 1);
        add(0, 16'h0003, 4'h0, 16'h0000, 4'h0, 0, 16'h000A, 16'h0003, 4'h1, 1);
        add(0, 16'h000C, 4'h0, 16'h0000, 4'h0, 0, 16'h000C, 16'h000C, 4'h0, 0);
        // zero hold, then release ignored while NORMAL
        add(0, 16'h0003, 4'h1, 16'h000A, 4'h0, 0, 16'h000A, 16'h0003, 4'h1, 1);
        add(0, 16'h000C, 4'h0, 16'h0000, 4'h1, 0, 16'h000C, 16'h000C, 4'h0, 0);
        add(0, 16'h0005, 4'h0, 16'h0000, 4'h1, 2, 16'h0005, 16'h0005, 4'h0, 0);
        // force beats release; force during HOLD cancels the hold; hold of 1
        add(0, 16'h0003, 4'h1, 16'h000A, 4'h0, 0, 16'h000A, 16'h0003, 4'h1, 1);
        add(0, 16'h000C, 4'h1, 16'h0007, 4'h1, 3, 16'h0007, 16'h000C, 4'h1, 1);
        add(0, 16'h0003, 4'h0, 16'h0000, 4'h1, 4, 16'h0007, 16'h0003, 4'h1, 1);
        add(0, 16'h000C, 4'h1, 16'h0009, 4'h0, 0, 16'h0009, 16'h000C, 4'h1, 1);
        add(0, 16'h0003, 4'h0, 16'h0000, 4'h0, 0, 16'h0009, 16'h0003, 4'h1, 1);
        add(0, 16'h0004, 4'h0, 16'h0000, 4'h1, 1, 16'h0009, 16'h0004, 4'h1, 1);
        add(0, 16'h0006, 4'h0, 16'h0000, 4'h0, 0, 16'h0006, 16'h0006, 4'h0, 0);
        // independence: ch1 forced F, ch2 forced 8 then held for 2
        add(0, 16'h4321, 4'h6, 16'h08F0, 4'h0, 0, 16'h48F1, 16'h4321, 4'h6, 1);
        add(0, 16'h8765, 4'h0, 16'h0000, 4'h4, 2, 16'h88F5, 16'h8765, 4'h6, 1);
        add(0, 16'hA9CB, 4'h0, 16'h0000, 4'h0, 0, 16'hA8FB, 16'hA9CB, 4'h6, 1);
        add(0, 16'h1111, 4'h0, 16'h0000, 4'h0, 0, 16'h11F1, 16'h1111, 4'h2, 1);
        add(0, 16'h2222, 4'h0, 16'h0000, 4'h2, 1, 16'h22F2, 16'h2222, 4'h2, 1);
        add(0, 16'h3333, 4'h0, 16'h0000, 4'h0, 0, 16'h3333, 16'h3333, 4'h0, 0);
        // ch3 maximum hold of 7
        add(0, 16'h5000, 4'h8, 16'hD000, 4'h0, 0, 16'hD000, 16'h5000, 4'h8, 1);
        add(0, 16'h5000, 4'h0, 16'h0000, 4'h8, 7, 16'hD000, 16'h5000, 4'h8, 1);
        for (int k = 0; k < 6; k++)
            add(0, 16'h5000, 4'h0, 16'h0000, 4'h0, 0, 16'hD000, 16'h5000, 4'h8, 1);
        add(0, 16'h5000, 4'h0, 16'h0000, 4'h0, 0, 16'h5000, 16'h5000, 4'h0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].r, vecs[k].i, vecs[k].fe, vecs[k].fv, vecs[k].rr, vecs[k].hc);
            chk($sformatf("v%0d out", k), dout, vecs[k].eo);
            chk($sformatf("v%0d shadow", k), dshadow, vecs[k].es);
            chk($sformatf("v%0d forced", k), {12'h0, dforced}, {12'h0, vecs[k].ef});
            chk($sformatf("v%0d busy", k), {15'h0, dbusy}, {15'h0, vecs[k].eb});
        end

        // Asynchronous reset between edges while ch0 is in HOLD with two cycles left.
        drive(0, 16'h0003, 4'h1, 16'h000A, 4'h0, 0);
        chk("rh force out", dout, 16'h000A);
        drive(0, 16'h000C, 4'h0, 16'h0000, 4'h1, 3);
        chk("rh hold out", dout, 16'h000A);
        chk("rh hold forced", {12'h0, dforced}, 16'h0001);
        @(negedge clk);
        rreq = '0; din = 16'h0003;
        #2 rst = 1'b1;
        #1;
        chk("rh async out", dout, 16'h0000);
        chk("rh async shadow", dshadow, 16'h0000);
        chk("rh async forced", {12'h0, dforced}, 16'h0000);
        chk("rh async busy", {15'h0, dbusy}, 16'h0000);
        drive(0, 16'h0007, 4'h0, 16'h0000, 4'h0, 0);
        chk("rh post out", dout, 16'h0007);
        chk("rh post forced", {12'h0, dforced}, 16'h0000);
        drive(0, 16'h000E, 4'h0, 16'h0000, 4'h0, 0);
        chk("rh post2 out", dout, 16'h000E);
        chk("rh post2 busy", {15'h0, dbusy}, 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
